// File: rtl/audio_fifo_pkg.sv
// Shared types and helpers for the audio sample FIFO.
package audio_fifo_pkg;

  typedef enum logic {
    DROP_NEW         = 1'b0,
    OVERWRITE_OLDEST = 1'b1
  } overflow_mode_t;

  typedef enum logic {
    ZERO_FILL   = 1'b0,
    REPEAT_LAST = 1'b1
  } underflow_mode_t;

  // Circular increment that also works for depths that are not a power of two.
  function automatic int unsigned ptr_wrap_inc(input int unsigned ptr, input int unsigned depth);
    return (ptr >= depth - 32'd1) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage

// File: rtl/sample_ram.sv
// Simple dual-port (1W/1R) frame RAM with a registered, enable-gated read port.
module sample_ram #(
  parameter int DEPTH = 128,
  parameter int WIDTH = 48
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;
  logic [WIDTH-1:0] rdata_d;

  // Read register holds its value when no read is requested.
  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = mem_q[raddr];
  end

  // Same-address read and write returns the old word.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
    rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/audio_sample_fifo.sv
// Single-clock audio sample FIFO with occupancy count, selectable overflow and
// underflow policies, and sticky error flags.
module audio_sample_fifo
  import audio_fifo_pkg::*;
#(
  parameter int BIT_WIDTH      = 24,
  parameter int CHANNELS       = 2,
  parameter int DEPTH          = 128,
  parameter int OVERFLOW_MODE  = 0,
  parameter int UNDERFLOW_MODE = 0,
  parameter int AFULL_LEVEL    = DEPTH - 4
) (
  input  logic                         clk_pixel,
  input  logic                         reset,
  input  logic                         audio_in_valid,
  input  logic [BIT_WIDTH-1:0]         audio_in [CHANNELS-1:0],
  input  logic                         packet_enable,
  output logic [BIT_WIDTH-1:0]         audio_out [CHANNELS-1:0],
  output logic                         audio_out_valid,
  output logic [$clog2(DEPTH+1)-1:0]   remaining,
  output logic                         almost_full,
  output logic                         overflow,
  output logic                         underflow,
  input  logic                         clear_flags
);

  localparam int FRAME_W = BIT_WIDTH * CHANNELS;
  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = $clog2(DEPTH + 1);
  localparam int unsigned DEPTH_U = DEPTH;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
  localparam overflow_mode_t  OVF_MODE = overflow_mode_t'(OVERFLOW_MODE != 0);
  localparam underflow_mode_t UDF_MODE = underflow_mode_t'(UNDERFLOW_MODE != 0);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;
  logic             out_vld_q, out_vld_d;
  logic             afull_q, afull_d;
  logic             zero_q, zero_d;

  logic full, empty;
  logic pop_ok, push_ok;
  logic ovf_evt, udf_evt, overwrite;
  logic ram_we, ram_re;
  logic [FRAME_W-1:0] ram_wdata;
  logic [FRAME_W-1:0] ram_rdata;

  always_comb begin
    ram_wdata = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      ram_wdata[c*BIT_WIDTH +: BIT_WIDTH] = audio_in[c];
    end
  end

  // A pop frees a slot in the same cycle, so a full FIFO still accepts a push
  // when a pop accompanies it; there is no empty-FIFO bypass.
  always_comb begin
    full      = (count_q == DEPTH_CNT);
    empty     = (count_q == '0);
    pop_ok    = packet_enable && !empty;
    push_ok   = audio_in_valid && (!full || pop_ok);
    ovf_evt   = audio_in_valid && full && !packet_enable;
    overwrite = ovf_evt && (OVF_MODE == OVERWRITE_OLDEST);
    udf_evt   = packet_enable && empty;
    ram_we    = (push_ok || overwrite) && !reset;
    ram_re    = pop_ok && !reset;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok || overwrite) begin
      wr_ptr_d = PTR_W'(ptr_wrap_inc(32'(wr_ptr_q), DEPTH_U));
    end
    if (pop_ok || overwrite) begin
      rd_ptr_d = PTR_W'(ptr_wrap_inc(32'(rd_ptr_q), DEPTH_U));
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Flags: clear first, then a coincident event sets the flag again.
  always_comb begin
    ovf_d     = (clear_flags ? 1'b0 : ovf_q) | ovf_evt;
    udf_d     = (clear_flags ? 1'b0 : udf_q) | udf_evt;
    out_vld_d = pop_ok;
    afull_d   = (int'(count_d) >= AFULL_LEVEL);
    zero_d    = zero_q;
    if (pop_ok) begin
      zero_d = 1'b0;
    end else if (udf_evt && (UDF_MODE == ZERO_FILL)) begin
      zero_d = 1'b1;
    end
  end

  // zero_q masks the RAM read register, which is never reset; it stands in for
  // a zeroed audio_out after reset and after a zero-fill underflow.
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      udf_q     <= 1'b0;
      out_vld_q <= 1'b0;
      afull_q   <= 1'b0;
      zero_q    <= 1'b1;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      udf_q     <= udf_d;
      out_vld_q <= out_vld_d;
      afull_q   <= afull_d;
      zero_q    <= zero_d;
    end
  end

  sample_ram #(
    .DEPTH (DEPTH),
    .WIDTH (FRAME_W)
  ) u_ram (
    .clk   (clk_pixel),
    .we    (ram_we),
    .waddr (wr_ptr_q),
    .wdata (ram_wdata),
    .re    (ram_re),
    .raddr (rd_ptr_q),
    .rdata (ram_rdata)
  );

  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      audio_out[c] = zero_q ? '0 : ram_rdata[c*BIT_WIDTH +: BIT_WIDTH];
    end
  end

  assign audio_out_valid = out_vld_q;
  assign remaining       = count_q;
  assign almost_full     = afull_q;
  assign overflow        = ovf_q;
  assign underflow       = udf_q;

endmodule

// File: tb/tb_audio_sample_fifo.sv
// Bench for audio_sample_fifo: three configurations driven in lockstep, checked
// against hand-computed vector tables and a queue-based reference model.
module tb_audio_sample_fifo;

  logic clk;
  logic rst, vin, pop, clr;
  logic [47:0] din_p;
  logic [23:0] din [1:0];

  logic [23:0] out_a [1:0];
  logic [23:0] out_b [1:0];
  logic [23:0] out_c [1:0];
  logic [47:0] out_a_p, out_b_p, out_c_p;
  logic vld_a, vld_b, vld_c;
  logic [2:0] rem_a, rem_b;
  logic [7:0] rem_c;
  logic af_a, af_b, af_c, ovf_a, ovf_b, ovf_c, udf_a, udf_b, udf_c;

  int vectors = 0;
  int miscompares = 0;

  assign din[0]  = din_p[23:0];
  assign din[1]  = din_p[47:24];
  assign out_a_p = {out_a[1], out_a[0]};
  assign out_b_p = {out_b[1], out_b[0]};
  assign out_c_p = {out_c[1], out_c[0]};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  audio_sample_fifo #(.DEPTH(5), .OVERFLOW_MODE(0), .UNDERFLOW_MODE(0)) dut_a (
    .clk_pixel(clk), .reset(rst), .audio_in_valid(vin), .audio_in(din),
    .packet_enable(pop), .audio_out(out_a), .audio_out_valid(vld_a),
    .remaining(rem_a), .almost_full(af_a), .overflow(ovf_a),
    .underflow(udf_a), .clear_flags(clr));

  audio_sample_fifo #(.DEPTH(5), .OVERFLOW_MODE(1), .UNDERFLOW_MODE(1)) dut_b (
    .clk_pixel(clk), .reset(rst), .audio_in_valid(vin), .audio_in(din),
    .packet_enable(pop), .audio_out(out_b), .audio_out_valid(vld_b),
    .remaining(rem_b), .almost_full(af_b), .overflow(ovf_b),
    .underflow(udf_b), .clear_flags(clr));

  audio_sample_fifo #(.DEPTH(128)) dut_c (
    .clk_pixel(clk), .reset(rst), .audio_in_valid(vin), .audio_in(din),
    .packet_enable(pop), .audio_out(out_c), .audio_out_valid(vld_c),
    .remaining(rem_c), .almost_full(af_c), .overflow(ovf_c),
    .underflow(udf_c), .clear_flags(clr));

  // Reference model: one frame queue per configuration.
  int          m_depth [3] = '{5, 5, 128};
  int          m_ovfm  [3] = '{0, 1, 0};
  int          m_udfm  [3] = '{0, 1, 0};
  int          m_af    [3] = '{1, 1, 124};
  logic [47:0] mq      [3][$];
  logic [47:0] m_out   [3];
  logic        m_vld   [3];
  logic        m_ovf   [3];
  logic        m_udf   [3];

  task automatic model_update();
    logic full, ovf_evt, udf_evt;
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        mq[i].delete();
        m_out[i] = '0;
        m_vld[i] = 1'b0;
        m_ovf[i] = 1'b0;
        m_udf[i] = 1'b0;
      end else begin
        full    = (mq[i].size() == m_depth[i]);
        ovf_evt = 1'b0;
        udf_evt = 1'b0;
        m_vld[i] = 1'b0;
        if (pop) begin
          if (mq[i].size() > 0) begin
            m_out[i] = mq[i].pop_front();
            m_vld[i] = 1'b1;
          end else begin
            udf_evt = 1'b1;
            if (m_udfm[i] == 0) m_out[i] = '0;
          end
        end
        if (vin) begin
          if (!full || pop) begin
            mq[i].push_back(din_p);
          end else begin
            ovf_evt = 1'b1;
            if (m_ovfm[i] == 1) begin
              void'(mq[i].pop_front());
              mq[i].push_back(din_p);
            end
          end
        end
        m_ovf[i] = (clr ? 1'b0 : m_ovf[i]) | ovf_evt;
        m_udf[i] = (clr ? 1'b0 : m_udf[i]) | udf_evt;
      end
    end
  endtask

  task automatic cmp(input int i, input string nm, input logic [47:0] o, input logic v,
                     input int rem, input logic af, input logic ov, input logic ud);
    logic eaf;
    eaf = (int'(mq[i].size()) >= m_af[i]);
    vectors++;
    if (o !== m_out[i] || v !== m_vld[i] || rem != int'(mq[i].size()) || af !== eaf ||
        ov !== m_ovf[i] || ud !== m_udf[i]) begin
      miscompares++;
      $display("FAIL model_%s @%0t: got out=%h vld=%b rem=%0d af=%b ovf=%b udf=%b, expected out=%h vld=%b rem=%0d af=%b ovf=%b udf=%b",
               nm, $time, o, v, rem, af, ov, ud, m_out[i], m_vld[i], mq[i].size(), eaf, m_ovf[i], m_udf[i]);
    end
  endtask

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got %h expected %h", nm, $time, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    cmp(0, "a", out_a_p, vld_a, int'(rem_a), af_a, ovf_a, udf_a);
    cmp(1, "b", out_b_p, vld_b, int'(rem_b), af_b, ovf_b, udf_b);
    cmp(2, "c", out_c_p, vld_c, int'(rem_c), af_c, ovf_c, udf_c);
  endtask

  task automatic drive(input logic r, input logic v, input logic p, input logic c,
                       input logic [47:0] d);
    rst = r; vin = v; pop = p; clr = c; din_p = d;
  endtask

  typedef struct {
    logic        rst;
    logic        vin;
    logic        pop;
    logic [47:0] din;
    logic [47:0] a_out;
    logic        a_vld;
    int          a_rem;
    logic        a_ovf;
    logic        a_udf;
    logic [47:0] b_out;
    int          b_rem;
  } vec_t;

  vec_t tbl [$];

  function automatic vec_t mkv(input logic r, input logic v, input logic p, input logic [47:0] d,
                               input logic [47:0] ao, input logic av, input int ar,
                               input logic aov, input logic aud,
                               input logic [47:0] bo, input int br);
    vec_t t;
    t.rst = r; t.vin = v; t.pop = p; t.din = d;
    t.a_out = ao; t.a_vld = av; t.a_rem = ar; t.a_ovf = aov; t.a_udf = aud;
    t.b_out = bo; t.b_rem = br;
    return t;
  endfunction

  logic [47:0] vals [1100];
  int push_pct [4] = '{50, 90, 20, 70};
  int pop_pct  [4] = '{50, 20, 90, 70};

  initial begin
    drive(1'b1, 1'b0, 1'b0, 1'b0, 48'd0);

    // Push 1..7 into DEPTH=5, then 6 pops; a drops, b overwrites.
    tbl.push_back(mkv(1'b1, 1'b0, 1'b0, 48'd0, 48'd0, 1'b0, 0, 1'b0, 1'b0, 48'd0, 0));
    for (int k = 1; k <= 7; k++)
      tbl.push_back(mkv(1'b0, 1'b1, 1'b0, 48'(k), 48'd0, 1'b0, (k < 5) ? k : 5,
                        (k > 5), 1'b0, 48'd0, (k < 5) ? k : 5));
    for (int j = 1; j <= 5; j++)
      tbl.push_back(mkv(1'b0, 1'b0, 1'b1, 48'd0, 48'(j), 1'b1, 5 - j, 1'b1, 1'b0,
                        48'(j + 2), 5 - j));
    tbl.push_back(mkv(1'b0, 1'b0, 1'b1, 48'd0, 48'd0, 1'b0, 0, 1'b1, 1'b1, 48'd7, 0));

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].vin, tbl[i].pop, 1'b0, tbl[i].din);
      step();
      chk($sformatf("tbl%0d_a_out", i), 64'(out_a_p), 64'(tbl[i].a_out));
      chk($sformatf("tbl%0d_a_vld", i), 64'(vld_a), 64'(tbl[i].a_vld));
      chk($sformatf("tbl%0d_a_rem", i), 64'(rem_a), 64'(tbl[i].a_rem));
      chk($sformatf("tbl%0d_a_ovf", i), 64'(ovf_a), 64'(tbl[i].a_ovf));
      chk($sformatf("tbl%0d_a_udf", i), 64'(udf_a), 64'(tbl[i].a_udf));
      chk($sformatf("tbl%0d_b_out", i), 64'(out_b_p), 64'(tbl[i].b_out));
      chk($sformatf("tbl%0d_b_rem", i), 64'(rem_b), 64'(tbl[i].b_rem));
    end

    // Full FIFO: push with pop in the same cycle.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 48'd0); step();
    for (int k = 10; k <= 14; k++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b0, 48'(k)); step();
    end
    drive(1'b0, 1'b1, 1'b1, 1'b0, 48'd15); step();
    chk("full_pushpop_out", 64'(out_a_p), 64'd10);
    chk("full_pushpop_vld", 64'(vld_a), 64'd1);
    chk("full_pushpop_rem", 64'(rem_a), 64'd5);
    chk("full_pushpop_ovf", 64'(ovf_a), 64'd0);
    chk("full_pushpop_b_out", 64'(out_b_p), 64'd10);

    // Drain, then push+pop on empty: underflow, frame stored.
    for (int k = 0; k < 5; k++) begin
      drive(1'b0, 1'b0, 1'b1, 1'b0, 48'd0); step();
    end
    chk("drain_last_b", 64'(out_b_p), 64'd15);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 48'hABCD); step();
    chk("empty_pushpop_b_udf", 64'(udf_b), 64'd1);
    chk("empty_pushpop_b_out", 64'(out_b_p), 64'd15);
    chk("empty_pushpop_b_vld", 64'(vld_b), 64'd0);
    chk("empty_pushpop_b_rem", 64'(rem_b), 64'd1);
    chk("empty_pushpop_a_out", 64'(out_a_p), 64'd0);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 48'd0); step();
    chk("after_empty_b_out", 64'(out_b_p), 64'hABCD);
    chk("after_empty_b_vld", 64'(vld_b), 64'd1);

    // Sticky overflow, clear alone, clear coincident with a new overflow.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 48'd0); step();
    for (int k = 0; k < 6; k++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b0, 48'(k + 40)); step();
    end
    chk("ovf_raised", 64'(ovf_a), 64'd1);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 48'd0); step();
    chk("ovf_cleared", 64'(ovf_a), 64'd0);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 48'd77); step();
    chk("ovf_set_wins", 64'(ovf_a), 64'd1);
    chk("ovf_set_wins_rem", 64'(rem_a), 64'd5);

    // Stream 1000 frames through DEPTH=128 with pointer wrap-around.
    for (int k = 0; k < 1100; k++) vals[k] = 48'({$urandom(), $urandom()});
    drive(1'b1, 1'b0, 1'b0, 1'b0, 48'd0); step();
    for (int k = 0; k < 100; k++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b0, vals[k]); step();
    end
    chk("stream_prefill_rem", 64'(rem_c), 64'd100);
    for (int k = 0; k < 1000; k++) begin
      drive(1'b0, 1'b1, 1'b1, 1'b0, vals[100 + k]); step();
      chk($sformatf("stream%0d_out", k), 64'(out_c_p), 64'(vals[k]));
      chk($sformatf("stream%0d_state", k), 64'({vld_c, rem_c, ovf_c, udf_c}),
          64'({1'b1, 8'd100, 1'b0, 1'b0}));
    end
    drive(1'b1, 1'b1, 1'b1, 1'b0, 48'd5); step();
    chk("midreset_out", 64'(out_c_p), 64'd0);
    chk("midreset_state", 64'({vld_c, rem_c, ovf_c, udf_c, af_c}), 64'd0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 48'd9); step();
    chk("first_push_after_reset", 64'(rem_c), 64'd1);

    // Randomised phases with varying push/pop pressure.
    for (int k = 0; k < 4000; k++) begin
      int ph;
      ph = (k / 400) % 4;
      drive(($urandom_range(0, 299) == 0),
            ($urandom_range(0, 99) < push_pct[ph]),
            ($urandom_range(0, 99) < pop_pct[ph]),
            ($urandom_range(0, 15) == 0),
            48'({$urandom(), $urandom()}));
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
